// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between two requesters (A: ALU path, B: load path) and the
// register file's single write port.
//   a_valid/a_ready/a_reg/a_data : requester A handshake and payload
//   b_valid/b_ready/b_reg/b_data : requester B handshake and payload
//   regWrite/W_reg/W_data        : register file write port
//   wr_src                       : source of the current write (0 = A, 1 = B)
// Modports: slave = arbiter side, master = requester/regfile side.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_reg;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_reg;
  logic [DATA_W-1:0] b_data;
  logic              regWrite;
  logic [ADDR_W-1:0] W_reg;
  logic [DATA_W-1:0] W_data;
  logic              wr_src;

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, regWrite, W_reg, W_data, wr_src
  );

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, regWrite, W_reg, W_data, wr_src
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between an ALU result
// requester (A) and a load result requester (B). B has fixed priority; A is
// forced through after losing MAX_WAIT consecutive contended cycles. The
// granted transfer is registered and drives the write port one cycle later.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous reset, active low
//   bus          : writeback interface (slave modport)
//   conflict_cnt : saturating count of cycles with both requesters valid
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam logic [3:0]       WAIT_MAX = 4'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  logic [3:0] wait_cnt;
  logic       a_grant;
  logic       b_grant;
  logic       both_valid;

  assign both_valid = bus.a_valid && bus.b_valid;

  // A wins when uncontended, or when it has been starved for MAX_WAIT cycles.
  // Both grants are gated by reset so nothing transfers while rst is low.
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (rst) begin
      a_grant = bus.a_valid && (!bus.b_valid || wait_cnt == WAIT_MAX);
      b_grant = bus.b_valid && !a_grant;
    end
  end

  assign bus.a_ready = a_grant;
  assign bus.b_ready = b_grant;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (a_grant)
        wait_cnt <= '0;
      else if (bus.a_valid && wait_cnt < WAIT_MAX)
        wait_cnt <= wait_cnt + 4'd1;

      if (both_valid && conflict_cnt != CNT_SAT)
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  // Output stage: address/data/source hold when idle; only the enable drops.
  // A transfer to r0 is accepted but never enables the write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.regWrite <= 1'b0;
      bus.W_reg    <= '0;
      bus.W_data   <= '0;
      bus.wr_src   <= 1'b0;
    end else if (a_grant) begin
      bus.regWrite <= (bus.a_reg != '0);
      bus.W_reg    <= bus.a_reg;
      bus.W_data   <= bus.a_data;
      bus.wr_src   <= 1'b0;
    end else if (b_grant) begin
      bus.regWrite <= (bus.b_reg != '0);
      bus.W_reg    <= bus.b_reg;
      bus.W_data   <= bus.b_data;
      bus.wr_src   <= 1'b1;
    end else begin
      bus.regWrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (CNT_W=4 build so counter
// saturation is reachable in a few cycles). Inputs change 1 ns after the
// rising edge; outputs are sampled 1 ns after that, away from the edge.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CNT_W-1:0] conflict_cnt;
  int               checks   = 0;
  int               failures = 0;
  logic [DATA_W-1:0] regmem [32];

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(3), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Register file model fed by the write port.
  always @(posedge clk)
    if (bus.regWrite) regmem[bus.W_reg] <= bus.W_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; returns 1 ns after the edge so inputs can be updated.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational readies before sampling.
  task automatic settle();
    #1;
  endtask

  logic        exp_a [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [4:0]  b_seq [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd4};

  initial begin
    for (int i = 0; i < 32; i++) regmem[i] = '0;
    bus.a_valid = 1'b1; bus.a_reg = 5'd9; bus.a_data = 32'hAAAA_0001;
    bus.b_valid = 1'b1; bus.b_reg = 5'd8; bus.b_data = 32'hBBBB_0001;

    // 1. Reset held two cycles with both valid
    #1; settle();
    chk("rst_a_ready", 64'(bus.a_ready), 64'd0);
    chk("rst_b_ready", 64'(bus.b_ready), 64'd0);
    cyc(); cyc(); settle();
    chk("rst_regWrite", 64'(bus.regWrite), 64'd0);
    chk("rst_W_reg", 64'(bus.W_reg), 64'd0);
    chk("rst_conflict", 64'(conflict_cnt), 64'd0);

    // 2. Release reset with a single A request: granted immediately
    rst = 1'b1;
    bus.b_valid = 1'b0;
    bus.a_reg = 5'd5; bus.a_data = 32'hDEAD_BEEF;
    settle();
    chk("a_only_a_ready", 64'(bus.a_ready), 64'd1);
    chk("a_only_b_ready", 64'(bus.b_ready), 64'd0);
    cyc();
    bus.a_valid = 1'b0;
    settle();
    chk("a_only_regWrite", 64'(bus.regWrite), 64'd1);
    chk("a_only_W_reg", 64'(bus.W_reg), 64'd5);
    chk("a_only_W_data", 64'(bus.W_data), 64'hDEAD_BEEF);
    chk("a_only_wr_src", 64'(bus.wr_src), 64'd0);
    chk("a_only_no_ready", 64'(bus.a_ready), 64'd0);
    cyc(); settle();
    chk("idle_regWrite", 64'(bus.regWrite), 64'd0);
    chk("idle_W_reg_hold", 64'(bus.W_reg), 64'd5);

    // 3. Priority + starvation: B,B,B,A,B
    bus.a_valid = 1'b1; bus.a_reg = 5'd9; bus.a_data = 32'h0000_00A9;
    bus.b_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.b_reg = b_seq[i]; bus.b_data = 32'h100 + 32'(b_seq[i]);
      settle();
      chk($sformatf("prio_a_ready%0d", i), 64'(bus.a_ready), 64'(exp_a[i]));
      chk($sformatf("prio_b_ready%0d", i), 64'(bus.b_ready), 64'(!exp_a[i]));
      cyc();
      settle();
      chk($sformatf("prio_wr_src%0d", i), 64'(bus.wr_src), 64'(!exp_a[i]));
      chk($sformatf("prio_W_reg%0d", i), 64'(bus.W_reg), exp_a[i] ? 64'd9 : 64'(b_seq[i]));
      chk($sformatf("prio_regWrite%0d", i), 64'(bus.regWrite), 64'd1);
    end
    chk("prio_conflict", 64'(conflict_cnt), 64'd5);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    cyc();

    // 4. r0 write suppressed but still accepted
    bus.b_valid = 1'b1; bus.b_reg = 5'd0; bus.b_data = 32'h0000_1234;
    settle();
    chk("r0_b_ready", 64'(bus.b_ready), 64'd1);
    cyc();
    bus.b_valid = 1'b0;
    settle();
    chk("r0_regWrite", 64'(bus.regWrite), 64'd0);
    chk("r0_W_data", 64'(bus.W_data), 64'h1234);
    chk("r0_wr_src", 64'(bus.wr_src), 64'd1);
    cyc();

    // 5. Same-destination conflict: B first, A last, A's value sticks
    bus.a_valid = 1'b1; bus.a_reg = 5'd7; bus.a_data = 32'h11;
    bus.b_valid = 1'b1; bus.b_reg = 5'd7; bus.b_data = 32'h22;
    settle();
    chk("same_b_ready", 64'(bus.b_ready), 64'd1);
    cyc();
    bus.b_valid = 1'b0;
    settle();
    chk("same_first_data", 64'(bus.W_data), 64'h22);
    chk("same_first_src", 64'(bus.wr_src), 64'd1);
    chk("same_a_ready", 64'(bus.a_ready), 64'd1);
    cyc();
    bus.a_valid = 1'b0;
    settle();
    chk("same_second_data", 64'(bus.W_data), 64'h11);
    chk("same_second_src", 64'(bus.wr_src), 64'd0);
    cyc(); settle();
    chk("same_regmem_r7", 64'(regmem[7]), 64'h11);
    chk("same_conflict", 64'(conflict_cnt), 64'd6);

    // 6. Conflict counter saturation (starts at 6)
    bus.a_valid = 1'b1; bus.a_reg = 5'd3; bus.a_data = 32'h33;
    bus.b_valid = 1'b1; bus.b_reg = 5'd4; bus.b_data = 32'h44;
    for (int i = 0; i < 8; i++) cyc();
    settle();
    chk("sat_pre", 64'(conflict_cnt), 64'd14);
    for (int i = 0; i < 11; i++) cyc();
    settle();
    chk("sat_hold", 64'(conflict_cnt), 64'hF);

    // Reset mid-transfer: no ready, write dropped, counters cleared
    rst = 1'b0;
    settle();
    chk("midrst_a_ready", 64'(bus.a_ready), 64'd0);
    chk("midrst_b_ready", 64'(bus.b_ready), 64'd0);
    cyc(); settle();
    chk("midrst_regWrite", 64'(bus.regWrite), 64'd0);
    chk("midrst_conflict", 64'(conflict_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
